// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/ready channel plus the decode-side valid/stall and redirect signals.
// Optional IFETCH_BNE_EN adds the decoder bne input.
interface ifetch_if #(
  parameter int CNT_W = 32
);
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ready;
  logic [31:0]      imem_rdata;
  logic             stall;
  logic             branch;
  logic             zero;
  logic             jump;
  logic [31:0]      branch_imm;
  logic [25:0]      jump_index;
`ifdef IFETCH_BNE_EN
  logic             bne;
`endif
  logic             instr_valid;
  logic [31:0]      instruction;
  logic [5:0]       opcode;
  logic [31:0]      pc_plus4;
  logic [CNT_W-1:0] retired_count;

  // master = fetch unit, slave = memory/decode side
  modport master (
`ifdef IFETCH_BNE_EN
    input  bne,
`endif
    output imem_req, imem_addr, instr_valid, instruction, opcode, pc_plus4, retired_count,
    input  imem_ready, imem_rdata, stall, branch, zero, jump, branch_imm, jump_index
  );

  modport slave (
`ifdef IFETCH_BNE_EN
    output bne,
`endif
    input  imem_req, imem_addr, instr_valid, instruction, opcode, pc_plus4, retired_count,
    output imem_ready, imem_rdata, stall, branch, zero, jump, branch_imm, jump_index
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: single-outstanding imem fetch, one held instruction for decode, next-PC on consume.
// Optional IFETCH_BNE_EN adds a bne-taken redirect below beq in priority.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic    clock,
  input  logic    reset,
  ifetch_if.master bus
);

  // state | meaning
  // IDLE  | out of reset, no request yet
  // FETCH | request outstanding at pc, waiting for imem_ready
  // HOLD  | instruction held for decode until a cycle without stall
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] next_pc;
  logic        br_taken;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_tgt = pc_plus4 + (bus.branch_imm << 2);
  assign jump_tgt   = {pc_plus4[31:28], bus.jump_index, 2'b00};

  always_comb begin
    br_taken = bus.branch & bus.zero;
`ifdef IFETCH_BNE_EN
    br_taken = br_taken | (bus.bne & ~bus.zero);
`endif
    if (bus.jump)
      next_pc = jump_tgt;
    else if (br_taken)
      next_pc = branch_tgt;
    else
      next_pc = pc_plus4;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (bus.imem_ready) begin
          instr_d = bus.imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!bus.stall) begin
          // low bits forced to zero so imem_addr stays word aligned
          pc_d    = {next_pc[31:2], 2'b00};
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC_A;
      instr_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.imem_req      = (state_q == FETCH);
  assign bus.imem_addr     = {pc_q[31:2], 2'b00};
  assign bus.instr_valid   = (state_q == HOLD);
  assign bus.instruction   = instr_q;
  assign bus.opcode        = instr_q[31:26];
  assign bus.pc_plus4      = pc_plus4;
  assign bus.retired_count = cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a vector table of redirects plus a queue of expected fetch addresses.
module tb_ifetch_unit;
  logic clock;
  logic reset;

  ifetch_if #(.CNT_W(32)) bus ();

  ifetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          dly;
    int          stl;
    logic        br;
    logic        z;
    logic        j;
    logic [31:0] imm;
    logic [25:0] idx;
    logic [31:0] nxt;
  } vec_t;

  vec_t        vt [14];
  logic [31:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_fetch(input int dly);
    logic [31:0] ea;
    for (int i = 0; i < 8 && !bus.imem_req; i++) @(negedge clock);
    check("fetch_req", 32'(bus.imem_req), 32'h1);
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'h1, 32'h0);
      ea = 32'h0;
    end else begin
      ea = exp_q.pop_front();
    end
    check("fetch_addr", bus.imem_addr, ea);
    check("fetch_valid_lo", 32'(bus.instr_valid), 32'h0);
    for (int i = 0; i < dly; i++) begin
      bus.imem_ready = 1'b0;
      @(negedge clock);
      check("wait_req", 32'(bus.imem_req), 32'h1);
      check("wait_addr", bus.imem_addr, ea);
      check("wait_valid", 32'(bus.instr_valid), 32'h0);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = ~ea;
    @(negedge clock);
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    check("hold_valid", 32'(bus.instr_valid), 32'h1);
    check("hold_req", 32'(bus.imem_req), 32'h0);
    check("hold_instr", bus.instruction, ~ea);
    check("hold_opcode", 32'(bus.opcode), 32'((~ea) >> 26));
    check("hold_pc4", bus.pc_plus4, ea + 32'd4);
  endtask

  task automatic do_consume(input vec_t v);
    logic [31:0] ins, p4;
    ins = bus.instruction;
    p4  = bus.pc_plus4;
    bus.branch     = v.br;
    bus.zero       = v.z;
    bus.jump       = v.j;
    bus.branch_imm = v.imm;
    bus.jump_index = v.idx;
    bus.stall      = 1'b1;
    for (int i = 0; i < v.stl; i++) begin
      @(negedge clock);
      check("stall_valid", 32'(bus.instr_valid), 32'h1);
      check("stall_req", 32'(bus.imem_req), 32'h0);
      check("stall_instr", bus.instruction, ins);
      check("stall_pc4", bus.pc_plus4, p4);
      check("stall_cnt", bus.retired_count, exp_cnt);
    end
    bus.stall = 1'b0;
    @(negedge clock);
    exp_cnt++;
    check("retired", bus.retired_count, exp_cnt);
    check("post_valid", 32'(bus.instr_valid), 32'h0);
    bus.branch = 1'b0;
    bus.zero   = 1'b0;
    bus.jump   = 1'b0;
    exp_q.push_back(v.nxt);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         26'h0,       32'h0000_0004};
    vt[1]  = '{0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         26'h0,       32'h0000_0008};
    vt[2]  = '{0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         26'h0,       32'h0000_000C};
    vt[3]  = '{5, 0, 1'b0, 1'b0, 1'b0, 32'h0,         26'h0,       32'h0000_0010};
    vt[4]  = '{0, 4, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0,       32'h0000_000C};
    vt[5]  = '{0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         26'h0,       32'h0000_0010};
    vt[6]  = '{0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'h0,       32'h0000_0014};
    vt[7]  = '{0, 0, 1'b1, 1'b1, 1'b0, 32'h0FFF_FFFB, 26'h0,       32'h4000_0004};
    vt[8]  = '{0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0005, 26'h0000100, 32'h4000_0400};
    vt[9]  = '{0, 0, 1'b1, 1'b1, 1'b0, 32'h2FFF_FEFE, 26'h0,       32'hFFFF_FFFC};
    vt[10] = '{0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         26'h0,       32'h0000_0000};
    vt[11] = '{0, 0, 1'b0, 1'b0, 1'b1, 32'h0,         26'h3FFFFFF, 32'h0FFF_FFFC};
    vt[12] = '{0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0005, 26'h0,       32'h1000_0000};
    vt[13] = '{2, 1, 1'b1, 1'b1, 1'b0, 32'h0000_0001, 26'h0,       32'h1000_0008};

    reset          = 1'b1;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.stall      = 1'b0;
    bus.branch     = 1'b0;
    bus.zero       = 1'b0;
    bus.jump       = 1'b0;
    bus.branch_imm = 32'h0;
    bus.jump_index = 26'h0;
`ifdef IFETCH_BNE_EN
    bus.bne        = 1'b0;
`endif
    repeat (2) @(negedge clock);
    check("rst_req", 32'(bus.imem_req), 32'h0);
    check("rst_valid", 32'(bus.instr_valid), 32'h0);
    check("rst_opcode", 32'(bus.opcode), 32'h0);
    check("rst_pc4", bus.pc_plus4, 32'h4);
    check("rst_cnt", bus.retired_count, 32'h0);
    reset = 1'b0;
    exp_q.push_back(32'h0);

    for (int i = 0; i < 14; i++) begin
      do_fetch(vt[i].dly);
      do_consume(vt[i]);
    end

    // reset mid-fetch while memory is not ready
    for (int i = 0; i < 8 && !bus.imem_req; i++) @(negedge clock);
    check("mid_req", 32'(bus.imem_req), 32'h1);
    if (exp_q.size() != 0) check("mid_addr", bus.imem_addr, exp_q.pop_front());
    bus.imem_ready = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_req", 32'(bus.imem_req), 32'h0);
    check("arst_cnt", bus.retired_count, 32'h0);
    check("arst_valid", 32'(bus.instr_valid), 32'h0);
    check("arst_addr", bus.imem_addr, 32'h0);
    check("arst_pc4", bus.pc_plus4, 32'h4);
    @(negedge clock);
    reset   = 1'b0;
    exp_cnt = 32'h0;
    exp_q.push_back(32'h0);
    do_fetch(0);
    do_consume(vt[0]);
    do_fetch(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
